scope_capture: RTL and testbench
================================

# scope_capture

Triggered, double-buffered sample capture engine for the oscilloscope lab: the next generation of the free-running scope. It takes a signed audio sample stream (e.g. the 24-bit microphone input) and waits for a programmable level-crossing trigger, with an auto-trigger fallback. It then records `depth` decimated and scaled samples into a back buffer and swaps that buffer to the display side only at a frame boundary, so the picture never tears. The block sits between the sample source and the pixel/graphics logic of `lab_top`, and also reports the measured signal period.

## Interface
Parameters:
- `w_sample`, 24, width of the signed input sample
- `depth`, 640, samples per capture (one per display column group)
- `w_x`, $clog2(depth), read-address width
- `w_y`, 10, width of the signed scaled output sample
- `sample_shift`, 8, arithmetic right shift applied to each sample before clipping
- `w_decim`, 3, width of the decimation exponent
- `w_period`, 20, width of the period counter
- `auto_timeout`, 2**20, number of `sample_valid` strobes without a trigger before the block forces one (auto mode)

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous, active-low reset
- `sample_valid` in 1: one-cycle strobe qualifying `sample`
- `sample` in `w_sample`: signed sample
- `trig_level` in `w_sample`: signed trigger threshold
- `trig_falling` in 1: 0 = rising edge, 1 = falling edge
- `auto_mode` in 1: enables the auto-trigger timeout
- `decim_log2` in `w_decim`: store every 2^n-th accepted sample
- `frame_done` in 1: one-cycle pulse from the display at end of frame
- `rd_x` in `w_x`: display read index
- `rd_y` out `w_y`: signed scaled sample at `rd_x`
- `rd_valid` out 1: `rd_y` is from a completed capture
- `trig_seen` out 1: one-cycle pulse when a capture starts
- `period` out `w_period`: strobes between consecutive rising crossings of `trig_level`
- `period_valid` out 1: at least one full period has been measured

## Operation
- **States** (`scope_state_t`): `WAIT_TRIG`, `CAPTURE`, `FULL`. Reset state is `WAIT_TRIG`.
- **Trigger.** Evaluated only on `sample_valid`, using `prev` (the last valid sample) and `sample`.
  - Rising: `prev < trig_level && sample >= trig_level`, signed compare.
  - Falling: `prev >= trig_level && sample < trig_level`.
  - The first valid sample after reset has no `prev` and cannot trigger.
- **Auto trigger.** In `WAIT_TRIG` with `auto_mode = 1`, the timeout counter increments per strobe. When it reaches `auto_timeout - 1`, the block triggers on that strobe. The counter clears on every state entry.
- **`WAIT_TRIG` → `CAPTURE`** on trigger. `trig_seen` pulses. The triggering sample is stored at index 0, and the decimation counter is cleared.
- **`CAPTURE`.**
  - Each `sample_valid` increments the decimation counter.
  - A sample is stored when the counter reaches `2^decim_log2 - 1`; the counter then wraps to 0.
  - `decim_log2` is latched at trigger time; changes take effect at the next capture.
  - After index `depth - 1` is written → `FULL`.
- **`FULL`.** The block ignores samples. On `frame_done` it swaps banks, sets `rd_valid`, and returns to `WAIT_TRIG`.
- **Ignored or concurrent events.**
  - `frame_done` in any other state is ignored; the display keeps the old bank.
  - `frame_done` in the same cycle as the final write does not swap; the swap waits for the next `frame_done`.
- **Scaling.** `s = sample >>> sample_shift`, clipped to [-(2^(w_y-1)-1), 2^(w_y-1)-1], then truncated to `w_y` bits. The clip is symmetric, so the value -2^(w_y-1) never appears.
- **Period.**
  - The counter counts `sample_valid` strobes and saturates at all-ones.
  - On every rising crossing of `trig_level` (regardless of `trig_falling`), `period` takes the count + 1 and the count clears.
  - `period_valid` is set from the second crossing after reset.
- **Reset** (async, `rst_n` low, including mid-capture):
  - State `WAIT_TRIG`, write bank 0, display bank 1.
  - `rd_valid`, `trig_seen`, `period_valid` = 0; `period` = 0; all counters 0; `prev` invalid.
  - RAM contents are not reset; `rd_valid` gates their use.

## Timing
- Read latency 1 cycle: `rd_y` reflects the `rd_x` presented in the previous cycle and is undefined while `rd_valid = 0`. The display side supplies `rd_x < depth`.
- Bank swap takes effect on the clock edge that samples `frame_done`; `rd_y` comes from the new bank starting with the address presented in that cycle.
- `trig_seen` is registered and asserted in the cycle after the triggering strobe.
- `period` / `period_valid` update one cycle after the crossing strobe.
- A capture with `decim_log2 = n` takes exactly `1 + (depth-1)*2^n` strobes, counting the trigger strobe.

## Structure
- **Package `scope_pkg`:** `scope_state_t` enum, and the `SCOPE_EDGE_RISING` / `SCOPE_EDGE_FALLING` constants.
- **Sub-module `scope_bank_ram`:** two-bank simple dual-port RAM, `2*depth` × `w_y`, bank select as the address MSB, registered read. Instantiated once.
- **`scope_capture` itself:** FSM, trigger/decimation/timeout/period counters, scaling.

## Test plan
- **Rising trigger.** Ramp -1000..+1000 step 1, `trig_level = 0`, `decim_log2 = 0`, `depth = 8`, `sample_shift = 0` → `trig_seen` once, at sample 0. Then `frame_done` → `rd_x` 0..7 reads 0..7, `rd_valid = 1`.
- **Decimation.** Same ramp, `decim_log2 = 2` → stored values 0, 4, 8, …, 28. Changing `decim_log2` mid-capture does not alter them.
- **Auto trigger.** DC input, `auto_mode = 1`, `auto_timeout = 16` → `trig_seen` on the 16th strobe. With `auto_mode = 0` → no trigger in 1000 strobes.
- **Clip and tear-free swap.**
  - Input +2^23-1 / -2^23 with `w_y = 10`, `sample_shift = 8` → `rd_y` = +511 / -511.
  - `frame_done` during `CAPTURE` → `rd_y` unchanged until the `frame_done` after `FULL`.
- **Period.** Square wave with period 100 strobes → `period = 100`, `period_valid` after the second rising edge. DC input → the counter saturates at 2^20-1 and `period` holds its last value.
- **Reset mid-capture.** Drop `rst_n` at capture index 3 → immediate `WAIT_TRIG`, `rd_valid = 0`, `period = 0`. A fresh trigger afterwards captures cleanly from index 0.

Source files
------------

// File: rtl/scope_pkg.sv
// scope_pkg: shared state type and trigger-edge encoding for the scope capture engine
package scope_pkg;
  typedef enum logic [1:0] {WAIT_TRIG, CAPTURE, FULL} scope_state_t;
  localparam logic SCOPE_EDGE_RISING = 1'b0;
  localparam logic SCOPE_EDGE_FALLING = 1'b1;
endpackage

// File: rtl/scope_bank_ram.sv
// scope_bank_ram: two-bank simple dual-port sample RAM, bank select as address MSB, registered read
module scope_bank_ram #(
  parameter int depth = 640,
  parameter int w_x = $clog2(depth),
  parameter int w_y = 10
) (
  input  logic           clk,
  input  logic           we,
  input  logic           wr_bank,
  input  logic [w_x-1:0] wr_addr,
  input  logic [w_y-1:0] wr_data,
  input  logic           rd_bank,
  input  logic [w_x-1:0] rd_addr,
  output logic [w_y-1:0] rd_data
);
  logic [w_y-1:0] mem [2][depth];
  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_addr] <= wr_data;
    rd_data <= mem[rd_bank][rd_addr];
  end
endmodule

// File: rtl/scope_capture.sv
// scope_capture: level-triggered, decimated, double-buffered capture of a signed sample stream
module scope_capture
  import scope_pkg::*;
#(
  parameter int w_sample = 24,
  parameter int depth = 640,
  parameter int w_x = $clog2(depth),
  parameter int w_y = 10,
  parameter int sample_shift = 8,
  parameter int w_decim = 3,
  parameter int w_period = 20,
  parameter int auto_timeout = 2**20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_valid,
  input  logic signed [w_sample-1:0] sample,
  input  logic signed [w_sample-1:0] trig_level,
  input  logic                       trig_falling,
  input  logic                       auto_mode,
  input  logic [w_decim-1:0]         decim_log2,
  input  logic                       frame_done,
  input  logic [w_x-1:0]             rd_x,
  output logic signed [w_y-1:0]      rd_y,
  output logic                       rd_valid,
  output logic                       trig_seen,
  output logic [w_period-1:0]        period,
  output logic                       period_valid
);
  localparam int w_dc = (1 << w_decim) - 1;
  localparam int w_to = $clog2(auto_timeout + 1);
  localparam int lim = (1 << (w_y - 1)) - 1;
  localparam logic signed [w_sample-1:0] hi = w_sample'(lim);
  localparam logic signed [w_sample-1:0] lo = -hi;
  scope_state_t state;
  logic signed [w_sample-1:0] prev, shifted;
  logic signed [w_y-1:0] scaled;
  logic prev_ok, seen_one, disp_bank, rise, fall, trig, hit, swap;
  logic [w_x-1:0] idx, wr_addr;
  logic [w_dc-1:0] dcnt, dmask;
  logic [w_decim-1:0] dlog;
  logic [w_to-1:0] tcnt;
  logic [w_period-1:0] pcnt, pnext;
  always_comb begin
    shifted = sample >>> sample_shift;
    scaled = w_y'(shifted > hi ? hi : shifted < lo ? lo : shifted);
    rise = prev_ok && prev < trig_level && sample >= trig_level;
    fall = prev_ok && prev >= trig_level && sample < trig_level;
    trig = sample_valid && state == WAIT_TRIG &&
           ((trig_falling == SCOPE_EDGE_RISING && rise) || (trig_falling == SCOPE_EDGE_FALLING && fall) ||
            (auto_mode && tcnt == w_to'(auto_timeout - 1)));
    dmask = ~({w_dc{1'b1}} << dlog);
    hit = sample_valid && state == CAPTURE && dcnt == dmask;
    wr_addr = trig ? '0 : idx;
    swap = state == FULL && frame_done;
    pnext = &pcnt ? pcnt : pcnt + 1'b1;
  end
  // the display bank flips on the swap edge itself, so the read issued in that cycle already sees the new capture
  scope_bank_ram #(.depth(depth), .w_x(w_x), .w_y(w_y)) ram (
    .clk,
    .we(trig || hit),
    .wr_bank(~disp_bank),
    .wr_addr,
    .wr_data(scaled),
    .rd_bank(disp_bank ^ swap),
    .rd_addr(rd_x),
    .rd_data(rd_y)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_TRIG;
      prev <= '0;
      prev_ok <= 1'b0;
      seen_one <= 1'b0;
      disp_bank <= 1'b1;
      idx <= '0;
      dcnt <= '0;
      dlog <= '0;
      tcnt <= '0;
      pcnt <= '0;
      period <= '0;
      period_valid <= 1'b0;
      rd_valid <= 1'b0;
      trig_seen <= 1'b0;
    end else begin
      trig_seen <= trig;
      if (sample_valid) begin
        prev <= sample;
        prev_ok <= 1'b1;
        pcnt <= rise ? '0 : pnext;
      end
      if (sample_valid && rise) begin
        period <= pnext;
        period_valid <= seen_one;
        seen_one <= 1'b1;
      end
      tcnt <= state != WAIT_TRIG ? '0 : tcnt + w_to'(sample_valid && auto_mode);
      case (state)
        WAIT_TRIG:
          if (trig) begin
            state <= CAPTURE;
            idx <= w_x'(1);
            dcnt <= '0;
            dlog <= decim_log2;
          end
        CAPTURE:
          if (hit) begin
            dcnt <= '0;
            idx <= idx + 1'b1;
            if (idx == w_x'(depth - 1)) state <= FULL;
          end else if (sample_valid) dcnt <= dcnt + 1'b1;
        FULL:
          if (frame_done) begin
            state <= WAIT_TRIG;
            disp_bank <= ~disp_bank;
            rd_valid <= 1'b1;
          end
        default: state <= WAIT_TRIG;
      endcase
    end
  end
endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: directed checks of trigger, decimation, auto trigger, clipping, bank swap, period and reset
module tb_scope_capture;
  logic clk = 0, rst_n = 0, sample_valid = 0, trig_falling = 0, auto_mode = 0, frame_done = 0;
  logic signed [23:0] sample = 0, trig_level = 0, trig_v = 0;
  logic signed [23:0] pmax = 24'sh7fffff, nmin = 24'sh800000;
  logic [2:0] decim_log2 = 0, rd_x = 0;
  logic signed [9:0] rd_y, rd_y2;
  logic rd_valid, rd_valid2, trig_seen, trig_seen2, period_valid, period_valid2;
  logic [19:0] period, period2;
  int checks = 0, failures = 0, trig_cnt = 0, tc = 0;

  always #5 clk = ~clk;

  scope_capture #(.depth(8), .sample_shift(0), .auto_timeout(16)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample), .trig_level(trig_level),
    .trig_falling(trig_falling), .auto_mode(auto_mode), .decim_log2(decim_log2), .frame_done(frame_done),
    .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .trig_seen(trig_seen), .period(period),
    .period_valid(period_valid));

  scope_capture #(.depth(8), .sample_shift(8), .auto_timeout(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample), .trig_level(trig_level),
    .trig_falling(trig_falling), .auto_mode(auto_mode), .decim_log2(decim_log2), .frame_done(frame_done),
    .rd_x(rd_x), .rd_y(rd_y2), .rd_valid(rd_valid2), .trig_seen(trig_seen2), .period(period2),
    .period_valid(period_valid2));

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic signed [23:0] v, input logic fd);
    sample = v;
    sample_valid = 1;
    frame_done = fd;
    @(negedge clk);
    sample_valid = 0;
    frame_done = 0;
    if (trig_seen) begin
      trig_cnt++;
      trig_v = v;
    end
  endtask

  task automatic pulse_frame();
    frame_done = 1;
    @(negedge clk);
    frame_done = 0;
  endtask

  task automatic read(input int x, input int e, input int e2, input string tag);
    rd_x = x[2:0];
    @(negedge clk);
    check($sformatf("%s%0d", tag, x), rd_y, e);
    check($sformatf("%s%0d_s8", tag, x), rd_y2, e2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_trig_seen", trig_seen, 0);
    check("rst_trig_seen_s8", trig_seen2, 0);
    check("rst_period", period, 0);
    check("rst_period_valid", period_valid, 0);
    rst_n = 1;
    @(negedge clk);
    // rising trigger on a ramp, capture 0..7
    for (int v = -1000; v <= 1000; v++) push(v, 0);
    check("rise_trig_cnt", trig_cnt, 1);
    check("rise_trig_at", trig_v, 0);
    check("rise_rd_valid_pre", rd_valid, 0);
    pulse_frame();
    check("rise_rd_valid", rd_valid, 1);
    check("rise_rd_valid_s8", rd_valid2, 1);
    for (int i = 0; i < 8; i++) read(i, i, 0, "rise_rd");
    // decimation by 4, mid-capture decim change and ignored frame_done
    decim_log2 = 2;
    for (int v = -1000; v < 28; v++) begin
      push(v, 0);
      if (v == 10) begin
        decim_log2 = 0;
        pulse_frame();
        read(3, 3, 0, "tear_mid");
      end
    end
    push(28, 1);
    read(7, 7, 0, "tear_last_write");
    check("decim_trig_cnt", trig_cnt, 2);
    rd_x = 5;
    frame_done = 1;
    @(negedge clk);
    frame_done = 0;
    check("swap_same_cycle", rd_y, 20);
    for (int i = 0; i < 8; i++) read(i, 4 * i, 0, "decim_rd");
    // auto trigger
    for (int k = 0; k < 1000; k++) push(5, 0);
    check("auto_off_no_trig", trig_cnt, 2);
    auto_mode = 1;
    for (int k = 0; k < 15; k++) push(5, 0);
    check("auto_15", trig_cnt, 2);
    push(5, 0);
    check("auto_16", trig_cnt, 3);
    auto_mode = 0;
    // clipping of full-scale samples
    for (int k = 1; k < 8; k++) push((k % 2) ? pmax : nmin, 0);
    pulse_frame();
    for (int i = 0; i < 8; i++) read(i, i == 0 ? 5 : (i % 2 ? 511 : -511), i == 0 ? 0 : (i % 2 ? 511 : -511), "clip_rd");
    // period measurement
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("per_rst_valid", period_valid, 0);
    repeat (50) push(-100, 0);
    push(100, 0);
    check("per_first", period, 51);
    check("per_first_valid", period_valid, 0);
    repeat (49) push(100, 0);
    repeat (50) push(-100, 0);
    push(100, 0);
    check("per_second", period, 100);
    check("per_second_valid", period_valid, 1);
    check("per_second_s8", period2, 100);
    check("per_second_valid_s8", period_valid2, 1);
    repeat (300) push(100, 0);
    check("per_dc_hold", period, 100);
    // reset in the middle of a capture
    pulse_frame();
    check("pre_rst_rd_valid", rd_valid, 1);
    push(-5, 0);
    for (int v = 0; v <= 3; v++) push(v, 0);
    rst_n = 0;
    #1;
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_period", period, 0);
    check("mid_rst_period_valid", period_valid, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    trig_level = 50;
    tc = trig_cnt;
    for (int v = 40; v <= 60; v++) push(v, 0);
    check("fresh_trig_cnt", trig_cnt, tc + 1);
    check("fresh_trig_at", trig_v, 50);
    check("fresh_rd_valid_pre", rd_valid, 0);
    pulse_frame();
    check("fresh_rd_valid", rd_valid, 1);
    for (int i = 0; i < 8; i++) read(i, 50 + i, 0, "fresh_rd");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
